// File: rtl/sw_debounce_pkg.sv
// Shared definitions for the switch debouncer.
//   deb_state_e           : per-channel qualification FSM state
//   SW_DEB_STABLE_DEFAULT : default hold time (1 ms at 50 MHz)
//   deb_cnt_w()           : counter width able to hold 0..stable
package sw_debounce_pkg;

  localparam int SW_DEB_STABLE_DEFAULT = 50000;

  typedef enum logic [0:0] {
    ST_STABLE = 1'b0,
    ST_WAIT   = 1'b1
  } deb_state_e;

  // Width of a counter that must reach 'stable' exactly. Guarded so a
  // degenerate parameter still yields a legal 1-bit vector.
  function automatic int deb_cnt_w(input int stable);
    return (stable < 1) ? 1 : $clog2(stable + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounced switch channel.
//   Clk    : clock, all state on rising edge
//   Resetn : async active-low reset
//   d      : raw asynchronous switch level
//   q      : debounced level
//   rise   : one-cycle pulse on q 0->1
//   fall   : one-cycle pulse on q 1->0
// The raw level passes through a two-flop synchroniser; only the second
// stage drives the qualification FSM. A new level is accepted once the
// synchronised value has differed from q for STABLE_CYCLES+1 consecutive
// edges (count 1..STABLE_CYCLES in WAIT plus the accepting edge).
module debounce_chan
  import sw_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = SW_DEB_STABLE_DEFAULT
) (
  input  logic Clk,
  input  logic Resetn,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  localparam int            CW      = deb_cnt_w(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  deb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_q, q_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_comb begin
    s1_d    = d;
    s2_d    = s1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (s2_q != q_q) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      ST_WAIT: begin
        if (s2_q == q_q) begin
          // Bounced back to the accepted level: drop the partial count.
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          q_d     = s2_q;
          state_d = ST_STABLE;
          cnt_d   = '0;
          rise_d  = s2_q;
          fall_d  = ~s2_q;
        end else begin
          // cnt_q < CNT_MAX here, so the increment cannot wrap.
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/sw_debouncer.sv
// Multi-channel switch debouncer: WIDTH independent debounce_chan lanes.
//   Clk    : clock
//   Resetn : async active-low reset
//   SW     : raw switch levels [WIDTH]
//   Q      : debounced levels [WIDTH]
//   Rise   : one-cycle 0->1 pulses [WIDTH]
//   Fall   : one-cycle 1->0 pulses [WIDTH]
module sw_debouncer
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH         = 2,
  parameter int STABLE_CYCLES = SW_DEB_STABLE_DEFAULT
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Rise,
  output logic [WIDTH-1:0] Fall
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_chan #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_chan (
      .Clk   (Clk),
      .Resetn(Resetn),
      .d     (SW[i]),
      .q     (Q[i]),
      .rise  (Rise[i]),
      .fall  (Fall[i])
    );
  end

endmodule

// File: tb/tb_sw_debouncer.sv
// Bench for sw_debouncer (WIDTH=2, STABLE_CYCLES=4). Reference model: the
// per-edge value captured by the first synchroniser stage is logged; q of a
// channel flips at an edge when the S+1 logged values ending two edges
// earlier all disagree with the current q.
module tb_sw_debouncer;
  localparam int W = 2;
  localparam int S = 4;

  logic         Clk;
  logic         Resetn;
  logic [W-1:0] SW;
  logic [W-1:0] Q, Rise, Fall;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq, mr, mf;
  logic [W-1:0] hist[$];
  int           rise_cnt;

  sw_debouncer #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
    .Clk(Clk), .Resetn(Resetn), .SW(SW), .Q(Q), .Rise(Rise), .Fall(Fall)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq = '0; mr = '0; mf = '0;
    hist.delete();
    hist.push_back('0);
  endtask

  task automatic model_edge(input logic rst_active, input logic [W-1:0] samp);
    int  sz;
    bit  all_diff;
    if (rst_active) begin
      model_reset();
    end else begin
      mr = '0; mf = '0;
      sz = hist.size();
      if (sz >= S + 2) begin
        for (int ch = 0; ch < W; ch++) begin
          all_diff = 1'b1;
          for (int k = sz - 2 - S; k <= sz - 2; k++)
            if (hist[k][ch] == mq[ch]) all_diff = 1'b0;
          if (all_diff) begin
            mq[ch] = ~mq[ch];
            if (mq[ch]) mr[ch] = 1'b1; else mf[ch] = 1'b1;
          end
        end
      end
      hist.push_back(samp);
      if (hist.size() > S + 2) void'(hist.pop_front());
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".q"}, Q, mq);
    chk({tag, ".rise"}, Rise, mr);
    chk({tag, ".fall"}, Fall, mf);
    chk({tag, ".excl"}, Rise & Fall, '0);
  endtask

  // One clock: sample inputs, clock edge, update model, check 1 time unit later.
  task automatic tick();
    logic [W-1:0] samp;
    logic         rst_active;
    rst_active = ~Resetn;
    samp       = SW;
    @(posedge Clk);
    model_edge(rst_active, samp);
    #1;
    if (Rise[0]) rise_cnt++;
    check_outs("edge");
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Assert reset between edges and check outputs clear without a clock.
  task automatic async_reset();
    #2;
    Resetn = 1'b0;
    model_reset();
    #1;
    chk("async.q", Q, '0);
    chk("async.rise", Rise, '0);
    chk("async.fall", Fall, '0);
  endtask

  initial begin
    rise_cnt = 0;
    Resetn = 1'b0;
    SW     = 2'b11;
    model_reset();
    #1;
    chk("rst0.q", Q, 2'b00);
    ticks(3);
    chk("rst.q", Q, 2'b00);
    chk("rst.rise", Rise, 2'b00);

    // Clean rise on channel 0.
    SW = 2'b00;
    Resetn = 1'b1;
    ticks(8);
    SW = 2'b01;
    ticks(6);
    chk("rise.pre_q", Q, 2'b00);
    tick();
    chk("rise.q", Q, 2'b01);
    chk("rise.pulse", Rise, 2'b01);
    tick();
    chk("rise.clr", Rise, 2'b00);

    // Asynchronous reset while Q=01.
    async_reset();
    ticks(2);
    SW = 2'b00;
    Resetn = 1'b1;
    ticks(8);

    // Bounce: high 3, low 2, then held high.
    rise_cnt = 0;
    SW = 2'b01; ticks(3);
    SW = 2'b00; ticks(2);
    SW = 2'b01; ticks(6);
    chk("bounce.none", Rise, 2'b00);
    tick();
    chk("bounce.pulse", Rise, 2'b01);
    ticks(6);
    chk("bounce.once", W'(rise_cnt), W'(1));

    // Clean fall.
    SW = 2'b00;
    ticks(6);
    tick();
    chk("fall.q", Q, 2'b00);
    chk("fall.pulse", Fall, 2'b01);
    tick();
    chk("fall.clr", Fall, 2'b00);

    // Independent channels changing together.
    SW = 2'b01;
    ticks(9);
    SW = 2'b10;
    ticks(6);
    tick();
    chk("indep.rise", Rise, 2'b10);
    chk("indep.fall", Fall, 2'b01);
    chk("indep.q", Q, 2'b10);
    ticks(2);

    // Reset mid-WAIT: ch0 count reaches 3 after the 5th edge.
    SW = 2'b11;
    ticks(5);
    chk("midwait.nopulse", Rise, 2'b00);
    async_reset();
    ticks(2);
    Resetn = 1'b1;
    ticks(6);
    chk("midwait.early", Rise, 2'b00);
    tick();
    chk("midwait.pulse", Rise, 2'b11);
    ticks(3);

    // Randomised bouncing with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 7) == 0) SW[b] = ~SW[b];
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
        ticks($urandom_range(1, 3));
        Resetn = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_debouncer.md
# sw_debouncer

Multi-channel switch/pushbutton conditioning stage in front of the lab flip-flop and latch circuits. It synchronises raw board inputs into the `Clk` domain and accepts a new level only after it holds for a programmable number of cycles. It outputs a clean level per channel plus one-cycle rise and fall pulses. Downstream stages take `Q` as a clean data or clock-enable source instead of a bouncing `SW` bit.

## Interface
- `WIDTH`, 2: number of independent channels.
- `STABLE_CYCLES`, 50000: consecutive cycles a new level must hold before acceptance; legal range ≥ 1. 50000 is 1 ms at 50 MHz.
- `Clk`  input  1: single clock; every register is on its rising edge.
- `Resetn`  input  1: reset is asynchronous and active-low.
- `SW`  input  WIDTH: raw asynchronous switch levels.
- `Q`  output  WIDTH: debounced level per channel.
- `Rise`  output  WIDTH: one-cycle pulse when `Q[i]` goes 0→1.
- `Fall`  output  WIDTH: one-cycle pulse when `Q[i]` goes 1→0.

## Operation
- Each channel is fully independent. No shared state or arbitration.
- Synchroniser:
  - Two-flop chain per channel: `s1 <= SW[i]`, `s2 <= s1`.
  - Only `s2` feeds the control logic.
- Per-channel FSM with states STABLE and WAIT. It holds a counter of width `$clog2(STABLE_CYCLES+1)`.
- STABLE:
  - If `s2 == Q`: stay, counter held at 0.
  - If `s2 != Q`: go to WAIT, counter ← 1.
- WAIT:
  - If `s2 == Q` (bounce back): go to STABLE, counter ← 0, no pulse.
  - Else if counter == `STABLE_CYCLES`: Q ← s2, go to STABLE, counter ← 0, pulse `Rise` or `Fall` as selected by the new Q.
  - Else: counter ← counter + 1.
- Counter arithmetic:
  - Unsigned.
  - Never exceeds `STABLE_CYCLES`.
  - No wrap is possible.
- `Rise`/`Fall`:
  - Registered, asserted on the same edge Q changes, cleared on the next edge.
  - `Rise[i]` and `Fall[i]` are never high together.
  - Different channels may pulse in the same cycle.
- Reset (`Resetn` low, asynchronous):
  - Clears s1, s2, Q, counter, Rise, Fall to 0 and the FSM to STABLE, immediately, with no clock needed.
  - A reset mid-WAIT discards the partial count.
  - After release, an input already high must requalify from scratch.

## Timing
- Latency: the raw input changes and then holds from before edge 0.
  - s1 updates at edge 0, s2 at edge 1.
  - WAIT is entered at edge 2 (count 1).
  - Count reaches `STABLE_CYCLES` at edge `STABLE_CYCLES+1`.
  - Q and the pulse update at edge `STABLE_CYCLES+2`.
- Any mismatch between s2 and Q during WAIT restarts qualification. The full `STABLE_CYCLES+2` edges count from the last raw transition.
- Pulse width: exactly one `Clk` cycle.
- Minimum spacing between successive pulses on one channel: `STABLE_CYCLES+1` cycles.
- Reset values of all outputs: `Q=0`, `Rise=0`, `Fall=0`.

## Structure
- Package `sw_debounce_pkg`:
  - FSM state enum (STABLE, WAIT).
  - Default constant `SW_DEB_STABLE_DEFAULT = 50000`.
- Sub-module `debounce_chan`: one channel with synchroniser, FSM, counter and pulse registers. Parameter is `STABLE_CYCLES`; ports are `Clk`, `Resetn`, `d`, `q`, `rise`, `fall`.
- Top `sw_debouncer` is a generate loop of `WIDTH` instances plus output bit concatenation. It contains no other logic.

## Test plan
All scenarios use `WIDTH=2` and `STABLE_CYCLES=4`, so latency is 6 edges.

- Reset:
  - Stimulus: `Resetn=0` with `SW=2'b11`, then drop `Resetn` between edges while `Q=2'b01`.
  - Required: `Q=00`, `Rise=00`, `Fall=00` throughout reset. Outputs clear at once, without a clock edge.
- Clean rise:
  - Stimulus: `SW[0]` 0→1 before edge 0, then held.
  - Required: `Q[0]=1` and `Rise[0]=1` after edge 6. `Rise[0]=0` after edge 7. `Q[1]`, `Fall` stay 0.
- Bounce rejection:
  - Stimulus: `SW[0]` high for 3 cycles, low for 2, then held high.
  - Required: no `Rise` during the glitch. `Rise[0]` pulses exactly once, 6 edges after the final 0→1.
- Clean fall:
  - Stimulus: from `Q[0]=1`, `SW[0]` 1→0 and held.
  - Required: `Q[0]=0` and `Fall[0]=1` after edge 6, a single cycle wide. `Rise[0]` stays 0.
- Independent channels:
  - Stimulus: `SW[1]` 0→1 at the same instant `SW[0]` 1→0.
  - Required: `Rise[1]` and `Fall[0]` high in the same cycle. Final `Q=2'b10`.
- Reset mid-WAIT:
  - Stimulus: `SW[0]` high; assert `Resetn` low when the count is 3; release with `SW[0]` still high.
  - Required: no pulse before or during reset. `Rise[0]` appears 6 edges after the first edge following release.
